// File: rtl/mode_manager.sv
// mode_manager: UI mode controller for the board shell.
// Arbitrates SPLASH / RUN (edit modes 1..NMODES) / HELP, muxes the matching
// display channel to disp and pulses mode_chg on every state or mode change.
// Optional feature: define MODE_MANAGER_TIMEOUT_EN to compile in the idle
// counter that returns RUN/HELP to SPLASH after TIMEOUT quiet cycles.
module mode_manager #(
  parameter int          NMODES  = 5,
  parameter int          DW      = 20,
  parameter int          NBTN    = 4,
  parameter logic [31:0] TIMEOUT = 32'd500_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NMODES-1:0]          sel,
  input  logic                       help,
  input  logic [NBTN-1:0]            btn,
  input  logic [(NMODES+2)*DW-1:0]   disp_in,
  output logic [DW-1:0]              disp,
  output logic [1:0]                 state_o,
  output logic [3:0]                 mode,
  output logic [3:0]                 topic,
  output logic                       mode_chg
);

  typedef enum logic [1:0] {
    SPLASH = 2'd0,
    RUN    = 2'd1,
    HELP   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          mode_reg, mode_next;
  logic [3:0]          topic_reg, topic_next;
  logic                mode_chg_reg, mode_chg_next;
  logic [NMODES-1:0]   sel_q;
  logic                help_q;
  logic [3:0]          pri;
  logic                act;
  logic                help_rise;
  logic                timeout_hit;

  // Unpack the flattened display bus into one entry per channel.
  logic [DW-1:0] chan [NMODES+2];
  for (genvar gi = 0; gi < NMODES + 2; gi++) begin : g_chan
    assign chan[gi] = disp_in[gi*DW +: DW];
  end

  // Priority encode: lowest set select bit wins, 0 when nothing is selected.
  always_comb begin
    pri = 4'd0;
    for (int i = NMODES - 1; i >= 0; i--) begin
      if (sel[i]) pri = 4'(i + 1);
    end
  end

  // Activity: any button held, or a switch level that differs from last cycle.
  assign act       = (|btn) || (sel != sel_q) || (help != help_q);
  assign help_rise = help & ~help_q;

`ifdef MODE_MANAGER_TIMEOUT_EN
  logic [31:0] idle_cnt_reg;

  assign timeout_hit = (state_reg != SPLASH) && !act && (idle_cnt_reg == TIMEOUT - 32'd1);

  // Idle counter: counts quiet cycles in RUN/HELP, restarts on activity or state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_reg <= 32'd0;
    end else if (state_next == SPLASH || act || state_next != state_reg) begin
      idle_cnt_reg <= 32'd0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // Next-state logic: timeout beats help, help beats mode select.
  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    topic_next = topic_reg;
    if (timeout_hit) begin
      state_next = SPLASH;
      topic_next = 4'd0;
    end else begin
      case (state_reg)
        SPLASH: begin
          if (help_rise) begin
            state_next = HELP;
            topic_next = pri;
          end else if (act) begin
            state_next = RUN;
            mode_next  = (pri != 4'd0) ? pri : 4'd1;
          end
        end
        RUN: begin
          if (help) begin
            state_next = HELP;
            topic_next = pri;
          end else if (pri != 4'd0) begin
            mode_next = pri;
          end
        end
        HELP: begin
          topic_next = pri;
          if (!help) begin
            state_next = RUN;
            if (pri != 4'd0) mode_next = pri;
          end
        end
        default: state_next = SPLASH;
      endcase
    end
    mode_chg_next = (state_next != state_reg) || (mode_next != mode_reg);
  end

  // State, mode, topic, change pulse and previous switch samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= SPLASH;
      mode_reg     <= 4'd1;
      topic_reg    <= 4'd0;
      mode_chg_reg <= 1'b0;
      sel_q        <= '0;
      help_q       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      topic_reg    <= topic_next;
      mode_chg_reg <= mode_chg_next;
      sel_q        <= sel;
      help_q       <= help;
    end
  end

  // Display mux straight from registered state; no extra pipeline stage.
  always_comb begin
    disp = chan[0];
    case (state_reg)
      RUN: begin
        for (int k = 1; k <= NMODES; k++) begin
          if (mode_reg == 4'(k)) disp = chan[k];
        end
      end
      HELP:    disp = chan[NMODES+1];
      default: disp = chan[0];
    endcase
  end

  assign state_o  = state_reg;
  assign mode     = mode_reg;
  assign topic    = topic_reg;
  assign mode_chg = mode_chg_reg;

endmodule
